// File: rtl/cvm_pkg.sv
// Shared definitions for the coffee vending controller family.
//   COIN_*      : 2-bit coin codes used on coin/change_coin
//   state_t     : controller states
//   coin_value(): maps a coin code to its credit value given the three denominations
package cvm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  function automatic int coin_value(input logic [1:0] code, input int v1, input int v2, input int v3);
    case (code)
      COIN_1:  return v1;
      COIN_2:  return v2;
      COIN_3:  return v3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cvm_change_gen.sv
// Greedy change picker: for a remaining amount, returns the largest coin that
// still fits and its value. Purely combinational.
//   amount : remaining credit to return
//   code   : coin code to emit (COIN_NONE when amount is below the smallest coin)
//   value  : credit value of that coin
module cvm_change_gen
  import cvm_pkg::*;
#(
  parameter int CREDIT_W  = 8,
  parameter int COIN1_VAL = 5,
  parameter int COIN2_VAL = 10,
  parameter int COIN3_VAL = 20
) (
  input  logic [CREDIT_W-1:0] amount,
  output logic [1:0]          code,
  output logic [CREDIT_W-1:0] value
);

  always_comb begin
    if (amount >= CREDIT_W'(COIN3_VAL))      code = COIN_3;
    else if (amount >= CREDIT_W'(COIN2_VAL)) code = COIN_2;
    else if (amount >= CREDIT_W'(COIN1_VAL)) code = COIN_1;
    else                                     code = COIN_NONE;
    value = CREDIT_W'(coin_value(code, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  end

endmodule

// File: rtl/cvm_multi_ctrl.sv
// Multi-product vending controller: collects coins, vends a selected product
// (with or without sugar), refunds on cancel and pays change greedily.
//   clk, rst      : clock / async active-low reset
//   coin          : inserted coin code (one coin per non-zero cycle)
//   sel_valid/sel_id/sugar : product selection strobe, product, sugar option
//   cancel        : refund request (honoured only while collecting)
//   credit        : current credit
//   busy          : dispensing or paying change
//   coffee / coffee_sugar / prod_out : dispense strobes and product
//   change_coin   : one returned coin per cycle while paying change
//   coin_reject / sel_reject : one-cycle pulses for refused coin / selection
// All outputs are registered. change_coin is non-zero exactly while in CHANGE:
// the first coin is issued on the edge that enters CHANGE and credit shows the
// amount still owed after that coin.
module cvm_multi_ctrl
  import cvm_pkg::*;
#(
  parameter int NUM_PROD    = 4,
  parameter int CREDIT_W    = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd15},
  parameter int COIN1_VAL   = 5,
  parameter int COIN2_VAL   = 10,
  parameter int COIN3_VAL   = 20,
  parameter int MAX_CREDIT  = 60,
  parameter int VEND_CYCLES = 4,
  localparam int ID_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                sugar,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coffee,
  output logic                coffee_sugar,
  output logic [ID_W-1:0]     prod_out,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                sel_reject
);

  localparam int SW    = CREDIT_W + 1;  // one extra bit so the ceiling check cannot wrap
  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  state_t              state;
  logic [CNT_W-1:0]    vend_cnt;
  logic [SW-1:0]       coin_val, sum, eff;
  logic                coin_ok, sel_ok;
  logic [CREDIT_W-1:0] price, chg_in, pick_val;
  logic [1:0]          pick_code;

  always_comb begin
    coin_val = SW'(coin_value(coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
    sum      = {1'b0, credit} + coin_val;
    coin_ok  = (coin != COIN_NONE) && (sum <= SW'(MAX_CREDIT));
    // Effective credit for this cycle's selection/cancel includes an accepted coin.
    eff      = coin_ok ? sum : {1'b0, credit};
    price    = '0;
    for (int i = 0; i < NUM_PROD; i++)
      if (int'(sel_id) == i) price = PRICES[i*CREDIT_W +: CREDIT_W];
    sel_ok   = (int'(sel_id) < NUM_PROD) && (eff >= {1'b0, price});
    // Change source: refund amount on cancel, otherwise the held credit.
    chg_in   = (state == ST_COLLECT && cancel) ? eff[CREDIT_W-1:0] : credit;
  end

  cvm_change_gen #(
    .CREDIT_W (CREDIT_W),
    .COIN1_VAL(COIN1_VAL),
    .COIN2_VAL(COIN2_VAL),
    .COIN3_VAL(COIN3_VAL)
  ) u_change (
    .amount(chg_in),
    .code  (pick_code),
    .value (pick_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      vend_cnt     <= '0;
      credit       <= '0;
      busy         <= 1'b0;
      coffee       <= 1'b0;
      coffee_sugar <= 1'b0;
      prod_out     <= '0;
      change_coin  <= COIN_NONE;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
    end else begin
      change_coin <= COIN_NONE;
      coin_reject <= (coin != COIN_NONE) && !coin_ok;
      sel_reject  <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (state == ST_COLLECT && cancel) begin
            // Cancel wins over a same-cycle selection; the selection is not flagged.
            state       <= ST_CHANGE;
            busy        <= 1'b1;
            change_coin <= pick_code;
            credit      <= chg_in - pick_val;
          end else if (sel_valid && sel_ok) begin
            state        <= ST_VEND;
            busy         <= 1'b1;
            credit       <= eff[CREDIT_W-1:0] - price;
            prod_out     <= sel_id;
            coffee       <= !sugar;
            coffee_sugar <= sugar;
            vend_cnt     <= CNT_W'(VEND_CYCLES - 1);
          end else begin
            sel_reject <= sel_valid;
            credit     <= eff[CREDIT_W-1:0];
            busy       <= 1'b0;
            state      <= (eff != '0) ? ST_COLLECT : ST_IDLE;
          end
        end
        ST_VEND: begin
          coin_reject <= (coin != COIN_NONE);
          sel_reject  <= sel_valid;
          if (vend_cnt == '0) begin
            coffee       <= 1'b0;
            coffee_sugar <= 1'b0;
            prod_out     <= '0;
            if (credit != '0) begin
              state       <= ST_CHANGE;
              change_coin <= pick_code;
              credit      <= credit - pick_val;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            vend_cnt <= vend_cnt - CNT_W'(1);
          end
        end
        ST_CHANGE: begin
          coin_reject <= (coin != COIN_NONE);
          sel_reject  <= sel_valid;
          if (credit != '0) begin
            change_coin <= pick_code;
            credit      <= credit - pick_val;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cvm_multi_ctrl.sv
module tb_cvm_multi_ctrl;

  localparam int NUM_PROD    = 4;
  localparam int CREDIT_W    = 8;
  localparam logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd15};
  localparam int COIN1_VAL   = 5;
  localparam int COIN2_VAL   = 10;
  localparam int COIN3_VAL   = 20;
  localparam int MAX_CREDIT  = 60;
  localparam int VEND_CYCLES = 4;
  localparam int ID_W        = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          coin = 2'b00;
  logic                sel_valid = 1'b0;
  logic [ID_W-1:0]     sel_id = '0;
  logic                sugar = 1'b0;
  logic                cancel = 1'b0;
  logic [CREDIT_W-1:0] credit;
  logic                busy, coffee, coffee_sugar, coin_reject, sel_reject;
  logic [ID_W-1:0]     prod_out;
  logic [1:0]          change_coin;

  cvm_multi_ctrl #(
    .NUM_PROD(NUM_PROD), .CREDIT_W(CREDIT_W), .PRICES(PRICES),
    .COIN1_VAL(COIN1_VAL), .COIN2_VAL(COIN2_VAL), .COIN3_VAL(COIN3_VAL),
    .MAX_CREDIT(MAX_CREDIT), .VEND_CYCLES(VEND_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_id(sel_id),
    .sugar(sugar), .cancel(cancel), .credit(credit), .busy(busy), .coffee(coffee),
    .coffee_sugar(coffee_sugar), .prod_out(prod_out), .change_coin(change_coin),
    .coin_reject(coin_reject), .sel_reject(sel_reject)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Once a vend or refund is accepted its whole future output sequence is known,
  // so it is laid out as a queue of per-cycle output records.
  typedef struct {
    bit disp;
    bit sug;
    int prod;
    int chg;
    int cred;
  } ent_t;

  ent_t sched[$];
  int   m_credit = 0;
  bit   e_busy = 0, e_coffee = 0, e_cs = 0, e_crej = 0, e_srej = 0;
  int   e_prod = 0, e_change = 0;

  function automatic int cval(input int code);
    case (code)
      1: return COIN1_VAL;
      2: return COIN2_VAL;
      3: return COIN3_VAL;
      default: return 0;
    endcase
  endfunction

  function automatic int price_of(input int id);
    logic [NUM_PROD*CREDIT_W-1:0] p;
    p = PRICES;
    return int'(p[id*CREDIT_W +: CREDIT_W]);
  endfunction

  task automatic push_change(input int amt);
    int a, c;
    a = amt;
    while (a > 0) begin
      c = (a >= COIN3_VAL) ? 3 : (a >= COIN2_VAL) ? 2 : 1;
      a -= cval(c);
      sched.push_back('{0, 0, 0, c, a});
    end
  endtask

  task automatic model_step();
    int  v, eff, pr, id;
    bit  acc;
    ent_t e;
    id     = int'(sel_id);
    e_crej = 0;
    e_srej = 0;
    if (e_busy) begin
      e_crej = (coin != 2'b00);
      e_srej = sel_valid;
    end else begin
      v      = cval(int'(coin));
      acc    = (coin != 2'b00) && (m_credit + v <= MAX_CREDIT);
      e_crej = (coin != 2'b00) && !acc;
      eff    = m_credit + (acc ? v : 0);
      pr     = (id < NUM_PROD) ? price_of(id) : 0;
      if (m_credit > 0 && cancel) begin
        push_change(eff);
      end else if (sel_valid && id < NUM_PROD && eff >= pr) begin
        for (int k = 0; k < VEND_CYCLES; k++) sched.push_back('{1, sugar, id, 0, eff - pr});
        push_change(eff - pr);
      end else begin
        e_srej   = sel_valid;
        m_credit = eff;
      end
    end
    if (sched.size() > 0) begin
      e        = sched.pop_front();
      e_busy   = 1;
      e_coffee = e.disp && !e.sug;
      e_cs     = e.disp && e.sug;
      e_prod   = e.prod;
      e_change = e.chg;
      m_credit = e.cred;
    end else begin
      e_busy   = 0;
      e_coffee = 0;
      e_cs     = 0;
      e_change = 0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched.delete();
      m_credit = 0;
      e_busy = 0; e_coffee = 0; e_cs = 0; e_crej = 0; e_srej = 0;
      e_prod = 0; e_change = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- compare process ----------------
  bit check_en = 0;
  always @(negedge clk) begin
    if (check_en) begin
      chk("credit", credit, m_credit);
      chk("busy", busy, e_busy);
      chk("coffee", coffee, e_coffee);
      chk("coffee_sugar", coffee_sugar, e_cs);
      chk("change_coin", change_coin, e_change);
      chk("coin_reject", coin_reject, e_crej);
      chk("sel_reject", sel_reject, e_srej);
      if (e_coffee || e_cs) chk("prod_out", prod_out, e_prod);
    end
  end

  // ---------------- stimulus ----------------
  // Inputs are applied just after a negedge and held for one cycle.
  task automatic drive(input logic [1:0] c, input bit sv, input int id, input bit sg, input bit cn);
    coin      = c;
    sel_valid = sv;
    sel_id    = ID_W'(id);
    sugar     = sg;
    cancel    = cn;
    @(negedge clk);
    coin = 2'b00; sel_valid = 0; sel_id = '0; sugar = 0; cancel = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 64 && busy; n++) @(negedge clk);
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int n;
    // Reset state
    #1 chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_en = 1;

    // Three small coins then product 0 with sugar (price 15)
    drive(2'b01, 0, 0, 0, 0); chk("t2_c5", credit, 5);
    drive(2'b01, 0, 0, 0, 0); chk("t2_c10", credit, 10);
    drive(2'b01, 0, 0, 0, 0); chk("t2_c15", credit, 15);
    drive(2'b00, 1, 0, 1, 0);
    chk("t2_credit0", credit, 0);
    n = 0;
    while (coffee_sugar && n < 20) begin n++; @(negedge clk); end
    chk("t2_sugar_len", n, VEND_CYCLES);
    chk("t2_idle", busy, 0);

    // 30 credit, product 1 (price 15) -> 15 change as 10 then 5
    drive(2'b10, 0, 0, 0, 0);
    drive(2'b11, 0, 0, 0, 0); chk("t3_c30", credit, 30);
    drive(2'b00, 1, 1, 0, 0);
    chk("t3_coffee", coffee, 1);
    chk("t3_rem", credit, 15);
    repeat (VEND_CYCLES) @(negedge clk);
    chk("t3_chg10", change_coin, 2'b10);
    @(negedge clk);
    chk("t3_chg5", change_coin, 2'b01);
    @(negedge clk);
    chk("t3_idle", busy, 0);

    // Short credit for product 3 (price 25), then cancel refunds
    drive(2'b10, 0, 0, 0, 0);
    drive(2'b00, 1, 3, 0, 0);
    chk("t4_selrej", sel_reject, 1);
    chk("t4_keep", credit, 10);
    drive(2'b00, 0, 0, 0, 1);
    chk("t4_refund", change_coin, 2'b10);
    chk("t4_credit0", credit, 0);
    wait_idle();

    // Credit ceiling and coins during vend
    drive(2'b11, 0, 0, 0, 0);
    drive(2'b11, 0, 0, 0, 0);
    drive(2'b10, 0, 0, 0, 0); chk("t5_c50", credit, 50);
    drive(2'b11, 0, 0, 0, 0);
    chk("t5_coinrej", coin_reject, 1);
    chk("t5_keep50", credit, 50);
    drive(2'b00, 1, 3, 0, 0); chk("t5_rem", credit, 25);
    drive(2'b01, 0, 0, 0, 0);
    chk("t5_vend_rej", coin_reject, 1);
    wait_idle();

    // Same-cycle coin completes the price
    drive(2'b10, 0, 0, 0, 0);
    drive(2'b01, 1, 1, 0, 0);
    chk("t6_vend", coffee, 1);
    chk("t6_prod", prod_out, 1);
    chk("t6_credit0", credit, 0);
    wait_idle();
    // Cancel beats a same-cycle selection; same-cycle coin is refunded too
    drive(2'b10, 0, 0, 0, 0);
    drive(2'b01, 1, 0, 0, 1);
    chk("t6_cancel_chg", change_coin, 2'b10);
    chk("t6_cancel_rem", credit, 5);
    chk("t6_no_vend", coffee, 0);
    wait_idle();

    // Asynchronous reset mid-vend
    drive(2'b11, 0, 0, 0, 0);
    drive(2'b00, 1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_coffee", coffee, 0);
    chk("ar_credit", credit, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_after", credit, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      coin      = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      sel_valid = ($urandom_range(0, 4) == 0);
      sel_id    = ID_W'($urandom_range(0, NUM_PROD - 1));
      sugar     = 1'($urandom_range(0, 1));
      cancel    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    coin = 2'b00; sel_valid = 0; cancel = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
